// File: rtl/register_tree_pq.sv
// Max-priority queue: QUEUE_SIZE leaf registers feeding a combinational
// comparator tree whose root is the current maximum, updated one op per cycle.
module register_tree_pq #(
  parameter int QUEUE_SIZE = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_wrt,
  input  logic                  i_read,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int TREE_DEPTH   = $clog2(QUEUE_SIZE);
  localparam int NODES_NEEDED = (2 ** (TREE_DEPTH + 1)) - 1;
  localparam int COMP_COUNT   = NODES_NEEDED / 2;
  localparam int IDX_W        = TREE_DEPTH;

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] val;
    logic [IDX_W-1:0]      idx;
  } node_t;

  logic [QUEUE_SIZE-1:0]                 valid_r;
  logic [QUEUE_SIZE-1:0][DATA_WIDTH-1:0] leaf_r;
  node_t                                 root_s;
  logic [IDX_W-1:0]                      free_idx_s;
  logic                                  full_s;
  logic                                  empty_s;

  // A valid child beats an invalid one; on equal values the left child wins.
  function automatic node_t pick(input node_t left, input node_t right);
    node_t win;
    if (right.vld && (!left.vld || (right.val > left.val))) begin
      win = right;
    end else begin
      win = left;
    end
    return win;
  endfunction

  // Heap-ordered tree: node n has children 2n+1 / 2n+2, leaves occupy the tail.
  function automatic node_t tree_max(
    input logic [QUEUE_SIZE-1:0]                 vld,
    input logic [QUEUE_SIZE-1:0][DATA_WIDTH-1:0] dat
  );
    node_t nodes [NODES_NEEDED];
    for (int k = 0; k < QUEUE_SIZE; k++) begin
      nodes[COMP_COUNT + k] = '{vld: vld[k], val: dat[k], idx: IDX_W'(k)};
    end
    for (int n = COMP_COUNT - 1; n >= 0; n--) begin
      nodes[n] = pick(nodes[2 * n + 1], nodes[2 * n + 2]);
    end
    return nodes[0];
  endfunction

  function automatic logic [IDX_W-1:0] first_free(input logic [QUEUE_SIZE-1:0] vld);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = QUEUE_SIZE - 1; k >= 0; k--) begin
      idx = vld[k] ? idx : IDX_W'(k);
    end
    return idx;
  endfunction

  // Root of the comparator tree and the insertion slot, both from registered state.
  always_comb begin
    root_s     = tree_max(valid_r, leaf_r);
    free_idx_s = first_free(valid_r);
    full_s     = &valid_r;
    empty_s    = ~|valid_r;
  end

  // Leaf storage update: enqueue, dequeue, replace or hold.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      valid_r <= '0;
      leaf_r  <= '0;
    end else begin
      case ({i_wrt, i_read})
        2'b10: begin
          if (!full_s) begin
            valid_r[free_idx_s] <= 1'b1;
            leaf_r[free_idx_s]  <= i_data;
          end
        end
        2'b01: begin
          if (!empty_s) begin
            valid_r[root_s.idx] <= 1'b0;
            leaf_r[root_s.idx]  <= '0;
          end
        end
        2'b11: begin
          // Replacing into an empty queue degenerates to a plain enqueue.
          if (!empty_s) begin
            leaf_r[root_s.idx] <= i_data;
          end else begin
            valid_r[free_idx_s] <= 1'b1;
            leaf_r[free_idx_s]  <= i_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_data  = root_s.vld ? root_s.val : '0;
  assign o_full  = full_s;
  assign o_empty = empty_s;

endmodule

// File: tb/tb_register_tree_pq.sv
// Scoreboard bench for register_tree_pq: a sorted-queue reference model
// predicts the outputs after every issued operation; a monitor compares.
module tb_register_tree_pq;

  localparam int QS = 8;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          i_wrt;
  logic          i_read;
  logic [DW-1:0] i_data;
  logic          o_full;
  logic          o_empty;
  logic [DW-1:0] o_data;

  register_tree_pq #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW)) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .i_wrt  (i_wrt),
    .i_read (i_read),
    .i_data (i_data),
    .o_full (o_full),
    .o_empty(o_empty),
    .o_data (o_data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int data;
    bit full;
    bit empty;
  } exp_t;

  exp_t exp_q[$];
  int   model_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.data  = (model_q.size() > 0) ? model_q[0] : 0;
    e.full  = (model_q.size() == QS);
    e.empty = (model_q.size() == 0);
    return e;
  endfunction

  // Reference: a multiset kept sorted largest-first.
  task automatic model_apply(input bit w, input bit r, input int d);
    if (w && !r) begin
      if (model_q.size() < QS) model_q.push_back(d);
    end else if (!w && r) begin
      if (model_q.size() > 0) void'(model_q.pop_front());
    end else if (w && r) begin
      if (model_q.size() > 0) model_q[0] = d;
      else model_q.push_back(d);
    end
    model_q.rsort();
  endtask

  task automatic op(input bit w, input bit r, input int d);
    @(negedge CLK);
    i_wrt  = w;
    i_read = r;
    i_data = DW'(d);
    model_apply(w, r, d);
    exp_q.push_back(model_out());
  endtask

  task automatic idle();
    @(negedge CLK);
    i_wrt  = 1'b0;
    i_read = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input int d, input bit f, input bit e);
    check({tag, "_data"}, int'(o_data), d);
    check({tag, "_full"}, int'(o_full), int'(f));
    check({tag, "_empty"}, int'(o_empty), int'(e));
  endtask

  // Monitor: compares the outputs settled after each edge against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_outputs("op", e.data, e.full, e.empty);
      end
    end
  end

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge CLK);
      budget++;
    end
    #3;
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int fill_vals[8] = '{5, 900, 17, 900, 0, 1024, 300, 42};
    int sel;
    RSTn   = 1'b0;
    i_wrt  = 1'b0;
    i_read = 1'b0;
    i_data = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_outputs("in_reset", 0, 1'b0, 1'b1);
    @(negedge CLK);
    RSTn = 1'b1;
    #1;
    check_outputs("after_reset", 0, 1'b0, 1'b1);

    op(1'b0, 1'b1, 0);
    foreach (fill_vals[k]) op(1'b1, 1'b0, fill_vals[k]);
    op(1'b1, 1'b0, 2000);
    repeat (4) op(1'b0, 1'b1, 0);
    op(1'b1, 1'b1, 3);
    op(1'b1, 1'b1, 1000);
    repeat (4) op(1'b0, 1'b1, 0);
    op(1'b1, 1'b1, 7);
    op(1'b0, 1'b1, 0);
    op(1'b1, 1'b0, 10);
    op(1'b1, 1'b0, 20);
    op(1'b0, 1'b1, 0);
    op(1'b1, 1'b1, 5);
    idle();
    drain();

    for (int i = 0; i < 160; i++) begin
      if (i == 80) begin
        idle();
        drain();
        @(negedge CLK);
        i_wrt  = 1'b1;
        i_data = DW'($urandom_range(0, 1024));
        #2;
        RSTn = 1'b0;
        model_q.delete();
        #1;
        check_outputs("async_reset", 0, 1'b0, 1'b1);
        @(posedge CLK);
        #1;
        check_outputs("reset_held", 0, 1'b0, 1'b1);
        @(negedge CLK);
        i_wrt = 1'b0;
        RSTn  = 1'b1;
      end
      if (model_q.size() == 0) sel = 0;
      else if (model_q.size() == QS) sel = 1;
      else sel = $urandom_range(0, 2);
      case (sel)
        0:       op(1'b1, 1'b0, $urandom_range(0, 1024));
        1:       op(1'b0, 1'b1, 0);
        default: op(1'b1, 1'b1, $urandom_range(0, 1024));
      endcase
    end
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
